// File: rtl/uart_inst_rx_pkg.sv
// Shared definitions for the host-driven instruction receive path:
// frame delimiter, parser state encoding and default sizing.
package uart_inst_rx_pkg;

  localparam logic [7:0] SOF_DEFAULT     = 8'hA5;
  localparam int         DEF_INST_W      = 8;
  localparam int         DEF_FIFO_AW     = 4;
  localparam int         DEF_PACE_W      = 17;

  // Parser states; ST_IDLE must stay the all-zero encoding so reset is obvious.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_DROP = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_inst_rx_inst_fifo.sv
// Instruction FIFO with tentative writes. Writes advance wr_tmp only;
// commit publishes them by copying wr_tmp into wr_ptr, rollback discards
// them by copying wr_ptr back into wr_tmp. Readers only ever see entries
// below wr_ptr, while the full flag uses wr_tmp so tentative entries
// reserve space. Pointers carry one extra MSB so full/empty are distinct.
module uart_inst_rx_inst_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          commit,
  input  logic          rollback,
  input  logic          pop,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic [AW:0]   count
);

  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  wr_tmp;
  logic [AW:0]  rd_ptr;
  logic [AW:0]  used_tmp;

  assign used_tmp = wr_tmp - rd_ptr;
  assign full     = (used_tmp == DEPTH_V);
  assign count    = wr_ptr - rd_ptr;
  assign rd_data  = mem[rd_ptr[AW-1:0]];

  // Pointer bookkeeping: rollback has priority over a tentative write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      wr_tmp <= '0;
      rd_ptr <= '0;
    end else begin
      if (rollback) begin
        wr_tmp <= wr_ptr;
      end else if (wr_en) begin
        wr_tmp <= wr_tmp + 1'b1;
      end
      if (commit) begin
        wr_ptr <= wr_tmp;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Storage array; the caller never writes while full.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_tmp[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/uart_inst_rx.sv
// Host instruction receiver: parses framed packets from the UART receive
// strobe, stores checksum-verified instructions, and issues them to the
// sequencer on a step pulse or at a paced automatic rate.
//
// Handshake: i_rx_valid is a one-cycle strobe with no backpressure; every
// strobed byte is consumed in the cycle it arrives. o_inst_valid is a
// one-cycle strobe with no ready; the sequencer must accept o_inst then.
module uart_inst_rx
  import uart_inst_rx_pkg::*;
#(
  parameter int         INST_W  = DEF_INST_W,
  parameter int         FIFO_AW = DEF_FIFO_AW,
  parameter int         PACE_W  = DEF_PACE_W,
  parameter logic [7:0] SOF     = SOF_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_valid,
  input  logic               i_step,
  input  logic               i_auto,
  input  logic               i_err_clr,
  output logic [INST_W-1:0]  o_inst,
  output logic               o_inst_valid,
  output logic [FIFO_AW:0]   o_fifo_cnt,
  output logic               o_busy,
  output logic               o_err_csum,
  output logic               o_err_ovf
);

  rx_state_e           state;
  logic [7:0]          remaining;
  logic [7:0]          csum;
  logic [PACE_W-1:0]   pace_cnt;
  logic                tick;
  logic                pop;
  logic                fifo_wr;
  logic                fifo_commit;
  logic                fifo_rollback;
  logic                fifo_full;
  logic [FIFO_AW:0]    fifo_cnt;
  logic [INST_W-1:0]   fifo_rd_data;

  uart_inst_rx_inst_fifo #(
    .W  (INST_W),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (fifo_wr),
    .wr_data  (i_rx_data[INST_W-1:0]),
    .commit   (fifo_commit),
    .rollback (fifo_rollback),
    .pop      (pop),
    .rd_data  (fifo_rd_data),
    .full     (fifo_full),
    .count    (fifo_cnt)
  );

  assign tick       = (pace_cnt == '0);
  assign pop        = (fifo_cnt != '0) & (i_step | (i_auto & tick));
  assign o_fifo_cnt = fifo_cnt;
  assign o_busy     = (state != ST_IDLE);

  // FIFO control decoded from the current state and the incoming byte.
  always_comb begin
    fifo_wr       = 1'b0;
    fifo_commit   = 1'b0;
    fifo_rollback = 1'b0;
    if (i_rx_valid) begin
      case (state)
        ST_LEN:  fifo_rollback = 1'b1;
        ST_DATA: begin
          if (fifo_full) fifo_rollback = 1'b1;
          else           fifo_wr       = 1'b1;
        end
        ST_CSUM: begin
          if (i_rx_data == csum) fifo_commit   = 1'b1;
          else                   fifo_rollback = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Frame parser and sticky error flags; a clear in the same cycle as a
  // set loses because the set assignment comes later in the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      remaining  <= '0;
      csum       <= '0;
      o_err_csum <= 1'b0;
      o_err_ovf  <= 1'b0;
    end else begin
      if (i_err_clr) begin
        o_err_csum <= 1'b0;
        o_err_ovf  <= 1'b0;
      end
      if (i_rx_valid) begin
        case (state)
          ST_IDLE: begin
            if (i_rx_data == SOF) state <= ST_LEN;
          end
          ST_LEN: begin
            if (i_rx_data == 8'd0) begin
              state <= ST_IDLE;
            end else begin
              remaining <= i_rx_data;
              csum      <= i_rx_data;
              state     <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (!fifo_full) begin
              csum <= csum ^ i_rx_data;
              if (remaining == 8'd1) state <= ST_CSUM;
              else                   remaining <= remaining - 8'd1;
            end else begin
              // This byte is consumed; the bytes still owed plus the CSUM
              // byte add up to the current remaining value, so it is kept.
              o_err_ovf <= 1'b1;
              state     <= ST_DROP;
            end
          end
          ST_CSUM: begin
            if (i_rx_data != csum) o_err_csum <= 1'b1;
            state <= ST_IDLE;
          end
          ST_DROP: begin
            remaining <= remaining - 8'd1;
            if (remaining == 8'd1) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Free-running pace counter; a tick occurs each time it sits at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pace_cnt <= '0;
    else        pace_cnt <= pace_cnt + 1'b1;
  end

  // Issue register: one-cycle strobe after a pop, data held until the next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_inst       <= '0;
      o_inst_valid <= 1'b0;
    end else begin
      o_inst_valid <= pop;
      if (pop) o_inst <= fifo_rd_data;
    end
  end

endmodule

// File: doc/uart_inst_rx.md
Name: uart_inst_rx

Overview:
- Receive-side counterpart to the sequencer-to-UART transmit path.
- Accepts bytes from the UART controller's receive outputs (o_rx_data/o_rx_valid) and parses framed instruction packets.
- Buffers checksum-verified instructions in a FIFO and issues them to the sequencer's instruction input (i_inst/i_inst_valid). Issue is either one per step pulse or automatically at a paced rate.
- Replaces the switch/button instruction source when the board is driven from a host PC.

Parameters:
- INST_W, 8, instruction width; must equal seq_in_width.
- FIFO_AW, 4, FIFO address width; depth = 2^FIFO_AW = 16 entries.
- PACE_W, 17, auto-issue interval of 2^PACE_W clk cycles (763 Hz at 100 MHz).
- SOF, 8'hA5, start-of-frame byte.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous active-low reset.
- i_rx_data  in  8  received byte; valid only when i_rx_valid=1.
- i_rx_valid  in  1  single-cycle strobe per received byte.
- i_step  in  1  single-cycle pulse; issue one instruction (debounced upstream).
- i_auto  in  1  level; 1 = paced automatic issue.
- i_err_clr  in  1  single-cycle pulse; clears sticky error flags.
- o_inst  out  INST_W  instruction to sequencer.
- o_inst_valid  out  1  single-cycle strobe qualifying o_inst.
- o_fifo_cnt  out  FIFO_AW+1  committed entries available to issue.
- o_busy  out  1  frame parse in progress (FSM not in IDLE).
- o_err_csum  out  1  sticky: frame rejected for bad checksum.
- o_err_ovf  out  1  sticky: frame rejected because the FIFO filled.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, all pointers 0, pace counter 0.
- Frame format: SOF, LEN (1..255), LEN instruction bytes, CSUM.
  - CSUM = XOR of LEN and all instruction bytes.
  - Only instruction bits [INST_W-1:0] of each byte are stored.
- Parser FSM; advances only on cycles with i_rx_valid=1:
  - IDLE: byte==SOF -> LEN; any other byte is discarded silently.
  - LEN: LEN==0 -> IDLE, no error. Otherwise latch remaining=LEN, csum=LEN, wr_tmp=wr_ptr -> DATA.
  - DATA, FIFO not full: write byte at wr_tmp, wr_tmp++, csum^=byte, remaining--. Last byte -> CSUM.
  - DATA, FIFO full (wr_tmp - rd_ptr == depth): set o_err_ovf, roll back wr_tmp=wr_ptr, set remaining = bytes left + 1 for the CSUM byte -> DROP. The offending byte is counted as consumed.
  - CSUM: byte==csum -> commit wr_ptr=wr_tmp. Otherwise set o_err_csum and roll back wr_tmp=wr_ptr. Either way -> IDLE.
  - DROP: remaining--; reaching 0 -> IDLE. SOF bytes inside DATA or DROP are data, not resync.
- Commit/rollback rules:
  - Uncommitted entries are never issued.
  - o_fifo_cnt = wr_ptr - rd_ptr (committed only).
  - The full check uses wr_tmp, so tentative entries reserve space.
- Issue:
  - Pace counter free-runs; tick when it wraps to 0.
  - pop = (o_fifo_cnt != 0) & (i_step | (i_auto & tick)).
  - On pop: o_inst <= mem[rd_ptr], rd_ptr++, o_inst_valid=1 on the following cycle (1-cycle latency, registered). o_inst holds its value until the next pop.
  - i_step while the FIFO is empty is ignored (not remembered).
  - i_step and tick in the same cycle produce one pop.
- Simultaneous events:
  - A pop and a DATA write in the same cycle are both honoured.
  - A pop in the same cycle as a CSUM commit sees the pre-commit count.
  - i_err_clr in the same cycle as an error set: the set wins.
- Pointers are FIFO_AW+1 bits and wrap naturally; full/empty are computed from the extra MSB.
- rst_n asserted mid-frame: the partial frame is lost, all entries are discarded, and the FSM returns to IDLE.

Decomposition:
- Shared package/include (alongside seq_definitions): SOF constant, FSM state encoding (IDLE, LEN, DATA, CSUM, DROP), default FIFO_AW and PACE_W.
- Sub-module inst_fifo: dual-pointer synchronous FIFO with commit/rollback. It owns the memory and the wr_tmp/wr_ptr/rd_ptr registers, and exposes write, commit, rollback, pop, full and count.

Test Plan:
- Good frame A5 03 11 22 33 (csum 03^11^22^33=03) -> o_fifo_cnt 0->3 after the CSUM byte. Three i_step pulses -> o_inst_valid pulses carrying 11, 22, 33, each one cycle after its step; a fourth step produces no strobe.
- Bad checksum A5 02 44 55 00 -> o_err_csum=1, o_fifo_cnt stays 0. A following good frame A5 01 66 67 commits 66; i_err_clr clears the flag.
- Overflow: LEN=20 with 16 entries pending -> o_err_ovf=1 on byte 17, remaining bytes and CSUM dropped, o_fifo_cnt=0. A subsequent good frame is accepted normally.
- Garbage 00 FF 5A before SOF, and A5 00 -> ignored, no errors, o_busy returns to 0. SOF as a data byte (A5 02 A5 01 A6) commits A5, 01.
- Auto mode: i_auto=1 with 4 committed entries -> four strobes spaced exactly 2^PACE_W cycles apart, then silence; an i_step coinciding with a tick yields one pop.
- Reset mid-frame after A5 04 10 20: assert rst_n=0 -> all outputs 0. A frame A5 01 77 76 after release commits exactly 77.
